mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Sits directly upstream of the RAM/I/O interface block, between the CPU pipeline's load/store stage and that interface.
- Accepts one load/store request at a time over a valid/ready handshake and drives the interface's enable/read_type/write_type/address/data_in from registers.
- Waits on busy/data_out_ready and returns exactly one response per request.
- Screens misaligned or illegal accesses and aborts hung accesses with a watchdog timeout.

Parameters:
AddressBitWidth, 32, address width
DataBitWidth, 32, data width
TimeoutCycles, 1_000_000, cycles in ACCESS before abort; 0 disables watchdog

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core presents request
req_ready  output  1  unit accepts request (high only in IDLE)
req_read_type  input  3  b000 none; bit2 sign-extend; [1:0] 01 byte, 10 half, 11 word
req_write_type  input  2  b00 none; 01 byte, 10 half, 11 word
req_address  input  AddressBitWidth  byte address
req_data  input  DataBitWidth  store data, low-aligned
resp_valid  output  1  one-cycle response pulse
resp_data  output  DataBitWidth  load result (0 for stores/errors)
resp_misaligned  output  1  valid with resp_valid
resp_timeout  output  1  valid with resp_valid
mem_enable  output  1  to interface enable
mem_read_type  output  3  to interface read_type
mem_write_type  output  2  to interface write_type
mem_address  output  AddressBitWidth  to interface address
mem_data_in  output  DataBitWidth  to interface data_in
mem_data_out  input  DataBitWidth  from interface data_out
mem_data_out_ready  input  1  from interface
mem_busy  input  1  from interface

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - req_ready=1.
  - All other outputs 0, including mem_enable, mem_read_type, mem_write_type and mem_address.
  - Watchdog counter 0.
  - Reset mid-ACCESS drops mem_enable immediately; the in-flight request is lost and no response is issued.
- All mem_* and resp_* outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request.
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
  - Illegal: both types zero, or both types nonzero.
  - Misaligned or illegal → go to RESPOND with resp_misaligned=1. No mem access is issued; mem_* stay 0.
  - Otherwise → go to ACCESS and load mem_* from the request, with mem_enable=1.
- ACCESS:
  - mem_* are held stable and req_ready=0.
  - Completion condition: !mem_busy && (write-only || mem_data_out_ready).
  - On completion:
    - Capture mem_data_out into resp_data for reads; resp_data=0 for stores.
    - Clear mem_enable, mem_read_type, mem_write_type and mem_address to 0 on the same edge.
    - Go to RESPOND.
  - Exactly one enabled cycle occurs for I/O addresses (busy=0, ready=1). This is mandatory: repeated cycles would double-issue side-effecting reads such as SD next-byte or UART-in clear.
  - Watchdog:
    - The counter increments each ACCESS cycle that does not complete.
    - When the counter reaches TimeoutCycles-1 without completion, clear mem_* and go to RESPOND with resp_timeout=1 and resp_data=0.
    - The counter clears on leaving ACCESS.
- RESPOND:
  - resp_valid=1 for exactly one cycle and req_ready=0.
  - Go to IDLE; resp_* flags clear the next cycle.
- Latency:
  - Accept edge N; mem_enable high in cycle N+1.
  - I/O or cache-hit completion at edge N+1; resp_valid in cycle N+2.
  - Minimum 3 cycles per request; no back-to-back overlap.
- mem_read_type/write_type are never nonzero while mem_enable=0.
- Stores pass req_data unchanged; byte-lane steering is done downstream.

Decomposition:
- Package mem_access_pkg:
  - state enum {IDLE, ACCESS, RESPOND}.
  - Localparams for read/write type encodings (RtNone, RtByte, RtHalf, RtWord, RtSignedBit, WtNone, WtByte, WtHalf, WtWord).
- Sub-module: mem_align_check, combinational, (read_type, write_type, address[1:0]) → misaligned, illegal.

Test Plan:
- Word load to 0x0000_0100 with mem_data_out=0xDEAD_BEEF, busy=0, ready=1 → mem_enable high exactly 1 cycle; resp_valid at N+2 with resp_data=0xDEAD_BEEF, flags 0.
- Store byte 0xA5 to 0x0000_0203 with busy held 5 cycles → mem_* stable for 6 cycles, mem_data_in=0x0000_00A5; resp_valid 1 cycle after busy falls, resp_data=0.
- Word load from 0xFFFF_FFE8 (I/O, busy=0, ready=1) → mem_enable and mem_read_type nonzero for exactly one cycle; resp_data equals mem_data_out.
- Half load from 0x0000_0101 → no mem_enable ever; resp_valid at N+1 with resp_misaligned=1. Same for word at 0x0000_0102, and for read_type=0 with write_type=0.
- TimeoutCycles=16, busy stuck 1 → mem_enable drops after 16 cycles; resp_timeout=1, resp_data=0; req_ready=1 the cycle after.
- Assert rst_n=0 mid-ACCESS → mem_enable=0 asynchronously, no resp_valid; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the load/store memory access unit.
// Read/write type codes match the RAM/I/O interface block.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    localparam logic [2:0] RtNone      = 3'b000;
    localparam logic [2:0] RtByte      = 3'b001;
    localparam logic [2:0] RtHalf      = 3'b010;
    localparam logic [2:0] RtWord      = 3'b011;
    localparam logic [2:0] RtSignedBit = 3'b100;

    localparam logic [1:0] WtNone = 2'b00;
    localparam logic [1:0] WtByte = 2'b01;
    localparam logic [1:0] WtHalf = 2'b10;
    localparam logic [1:0] WtWord = 2'b11;

endpackage

// File: rtl/mem_align_check.sv
// Screens a load/store request for illegal type combinations
// and for half/word accesses that are not naturally aligned.
module mem_align_check
    import mem_access_pkg::*;
(
    input  logic [2:0] read_type,
    input  logic [1:0] write_type,
    input  logic [1:0] address,
    output logic       misaligned,
    output logic       illegal
);

    logic       rd_on;
    logic       wr_on;
    logic [1:0] size;

    assign rd_on = (read_type != RtNone);
    assign wr_on = (write_type != WtNone);

    // A sign bit with no size is treated as illegal too.
    assign illegal = (rd_on == wr_on)
                   || (rd_on && (read_type[1:0] == 2'b00));

    assign size = rd_on ? read_type[1:0] : write_type;

    assign misaligned = ((size == WtHalf) && address[0])
                      || ((size == WtWord) && (address != 2'b00));

endmodule

// File: rtl/mem_access_unit.sv
// One-at-a-time load/store sequencer in front of the RAM/I/O interface,
// with alignment screening and a watchdog on hung accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int AddressBitWidth = 32,
    parameter int DataBitWidth    = 32,
    parameter int TimeoutCycles   = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_read_type,
    input  logic [1:0]                 req_write_type,
    input  logic [AddressBitWidth-1:0] req_address,
    input  logic [DataBitWidth-1:0]    req_data,
    output logic                       resp_valid,
    output logic [DataBitWidth-1:0]    resp_data,
    output logic                       resp_misaligned,
    output logic                       resp_timeout,
    output logic                       mem_enable,
    output logic [2:0]                 mem_read_type,
    output logic [1:0]                 mem_write_type,
    output logic [AddressBitWidth-1:0] mem_address,
    output logic [DataBitWidth-1:0]    mem_data_in,
    input  logic [DataBitWidth-1:0]    mem_data_out,
    input  logic                       mem_data_out_ready,
    input  logic                       mem_busy
);

    localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam int LastInt = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(LastInt);

    state_t                     state, state_n;
    logic [CntW-1:0]            cnt, cnt_n;
    logic                       en_n;
    logic [2:0]                 rt_n;
    logic [1:0]                 wt_n;
    logic [AddressBitWidth-1:0] addr_n;
    logic [DataBitWidth-1:0]    din_n;
    logic                       rv_n, mis_n, to_n;
    logic [DataBitWidth-1:0]    rd_n;
    logic                       bad_align, bad_type;
    logic                       write_only, done, wd_hit;

    mem_align_check u_align (
        .read_type  (req_read_type),
        .write_type (req_write_type),
        .address    (req_address[1:0]),
        .misaligned (bad_align),
        .illegal    (bad_type)
    );

    assign req_ready  = (state == IDLE);
    assign write_only = (mem_read_type == RtNone);
    assign done       = !mem_busy && (write_only || mem_data_out_ready);
    assign wd_hit     = (TimeoutCycles != 0) && (cnt == CntLast);

    // Next-state and next-output logic; mem_* hold unless changed below.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        en_n    = mem_enable;
        rt_n    = mem_read_type;
        wt_n    = mem_write_type;
        addr_n  = mem_address;
        din_n   = mem_data_in;
        rv_n    = 1'b0;
        mis_n   = 1'b0;
        to_n    = 1'b0;
        rd_n    = '0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_align || bad_type) begin
                        state_n = RESPOND;
                        rv_n    = 1'b1;
                        mis_n   = 1'b1;
                    end else begin
                        state_n = ACCESS;
                        en_n    = 1'b1;
                        rt_n    = req_read_type;
                        wt_n    = req_write_type;
                        addr_n  = req_address;
                        din_n   = req_data;
                    end
                end
            end
            ACCESS: begin
                if (done || wd_hit) begin
                    state_n = RESPOND;
                    rv_n    = 1'b1;
                    to_n    = !done;
                    rd_n    = (done && !write_only) ? mem_data_out : '0;
                    en_n    = 1'b0;
                    rt_n    = RtNone;
                    wt_n    = WtNone;
                    addr_n  = '0;
                    din_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESPOND: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, watchdog and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            mem_enable      <= 1'b0;
            mem_read_type   <= RtNone;
            mem_write_type  <= WtNone;
            mem_address     <= '0;
            mem_data_in     <= '0;
            resp_valid      <= 1'b0;
            resp_misaligned <= 1'b0;
            resp_timeout    <= 1'b0;
            resp_data       <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            mem_enable      <= en_n;
            mem_read_type   <= rt_n;
            mem_write_type  <= wt_n;
            mem_address     <= addr_n;
            mem_data_in     <= din_n;
            resp_valid      <= rv_n;
            resp_misaligned <= mis_n;
            resp_timeout    <= to_n;
            resp_data       <= rd_n;
        end
    end

endmodule
